// File: rtl/mem_bus_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mem_bus_arbiter
// Description : Two-requester arbiter for one mem_if bus. Fixed priority
//               (requester 0 wins); MEM_ARB_ROUND_ROBIN_EN alternates ties.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter #(
    parameter int LINE_BYTES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic [31:0]             r0_addr,
    input  logic [8*LINE_BYTES-1:0] r0_data_i,
    input  logic [LINE_BYTES-1:0]   r0_data_en,
    input  logic                    r0_read_en,
    input  logic                    r0_write_en,
    output logic [8*LINE_BYTES-1:0] r0_data_o,
    output logic                    r0_hit,
    output logic                    r0_done,

    input  logic [31:0]             r1_addr,
    input  logic [8*LINE_BYTES-1:0] r1_data_i,
    input  logic [LINE_BYTES-1:0]   r1_data_en,
    input  logic                    r1_read_en,
    input  logic                    r1_write_en,
    output logic [8*LINE_BYTES-1:0] r1_data_o,
    output logic                    r1_hit,
    output logic                    r1_done,

    output logic [31:0]             m_addr,
    output logic [8*LINE_BYTES-1:0] m_data_i,
    output logic [LINE_BYTES-1:0]   m_data_en,
    output logic                    m_read_en,
    output logic                    m_write_en,
    input  logic [8*LINE_BYTES-1:0] m_data_o,
    input  logic                    m_hit,
    input  logic                    m_done,

    output logic                    owner,
    output logic                    busy
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t     r_state;
    logic       r_owner;
    logic [1:0] r_doneq;

    logic w_r0_req;
    logic w_r1_req;
    logic w_owner_req;
    logic w_win;

    assign w_r0_req    = r0_read_en | r0_write_en;
    assign w_r1_req    = r1_read_en | r1_write_en;
    assign w_owner_req = r_owner ? w_r1_req : w_r0_req;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic r_last_owner;

    // Tie goes to whoever did not finish the previous transaction.
    assign w_win = w_r0_req ? (w_r1_req ? ~r_last_owner : 1'b0) : 1'b1;
`else
    assign w_win = ~w_r0_req;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_owner <= 1'b0;
            r_doneq <= 2'b00;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            r_last_owner <= 1'b1;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    r_doneq <= 2'b00;
                    if (w_r0_req || w_r1_req) begin
                        r_state <= BUSY;
                        r_owner <= w_win;
                    end
                end
                BUSY: begin
                    // Completion or abort both fall back to IDLE for re-arbitration.
                    if (m_done || !w_owner_req) begin
                        r_state <= IDLE;
                        r_doneq <= 2'b00;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        if (m_done) begin
                            r_last_owner <= r_owner;
                        end
`endif
                    end else if (m_hit) begin
                        r_doneq[r_owner] <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_doneq <= 2'b00;
                end
            endcase
        end
    end

    assign busy  = (r_state == BUSY);
    assign owner = r_owner;

    assign m_addr     = busy ? (r_owner ? r1_addr     : r0_addr)     : 32'd0;
    assign m_data_i   = busy ? (r_owner ? r1_data_i   : r0_data_i)   : '0;
    assign m_data_en  = busy ? (r_owner ? r1_data_en  : r0_data_en)  : '0;
    assign m_read_en  = busy & (r_owner ? r1_read_en  : r0_read_en);
    assign m_write_en = busy & (r_owner ? r1_write_en : r0_write_en);

    assign r0_hit  = m_hit & busy & ~r_owner;
    assign r1_hit  = m_hit & busy &  r_owner;
    assign r0_done = m_done & r_doneq[0];
    assign r1_done = m_done & r_doneq[1];

    // Read data is broadcast; only the requester seeing done consumes it.
    assign r0_data_o = rst_n ? m_data_o : '0;
    assign r1_data_o = rst_n ? m_data_o : '0;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mem_bus_arbiter
// Description : Scoreboard bench for mem_bus_arbiter with a scripted memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_bus_arbiter;

    localparam int LB = 4;
    localparam int DW = 8 * LB;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [31:0]   r0_addr, r1_addr, m_addr;
    logic [DW-1:0] r0_data_i, r1_data_i, r0_data_o, r1_data_o, m_data_i, m_data_o;
    logic [LB-1:0] r0_data_en, r1_data_en, m_data_en;
    logic          r0_read_en, r0_write_en, r0_hit, r0_done;
    logic          r1_read_en, r1_write_en, r1_hit, r1_done;
    logic          m_read_en, m_write_en, m_hit, m_done;
    logic          owner, busy;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.LINE_BYTES(LB)) dut (
        .clk(clk), .rst_n(rst_n),
        .r0_addr(r0_addr), .r0_data_i(r0_data_i), .r0_data_en(r0_data_en),
        .r0_read_en(r0_read_en), .r0_write_en(r0_write_en),
        .r0_data_o(r0_data_o), .r0_hit(r0_hit), .r0_done(r0_done),
        .r1_addr(r1_addr), .r1_data_i(r1_data_i), .r1_data_en(r1_data_en),
        .r1_read_en(r1_read_en), .r1_write_en(r1_write_en),
        .r1_data_o(r1_data_o), .r1_hit(r1_hit), .r1_done(r1_done),
        .m_addr(m_addr), .m_data_i(m_data_i), .m_data_en(m_data_en),
        .m_read_en(m_read_en), .m_write_en(m_write_en),
        .m_data_o(m_data_o), .m_hit(m_hit), .m_done(m_done),
        .owner(owner), .busy(busy)
    );

    typedef struct {
        logic        id;
        logic [31:0] addr;
        logic        rd;
        logic        wr;
        logic [3:0]  en;
        logic [31:0] data;
    } grant_t;

    typedef struct {
        logic        id;
        logic        rd;
        logic [31:0] data;
    } done_t;

    grant_t gq[$];
    done_t  dq[$];
    grant_t g_mon;
    done_t  d_mon;
    logic   cur_owner = 1'b0;
    logic   prev_busy = 1'b0;
    logic   model_last = 1'b1;
    int     n_checks = 0;
    int     n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        case (a)
            32'h100: return 32'hDEADBEEF;
            32'h300: return 32'hCAFEF00D;
            default: return a ^ 32'hA5A5A5A5;
        endcase
    endfunction

    function automatic logic tie_winner();
`ifdef MEM_ARB_ROUND_ROBIN_EN
        return ~model_last;
`else
        return 1'b0;
`endif
    endfunction

    task automatic push_grant(input logic id, input logic rd, input logic [31:0] addr,
                              input logic [31:0] data, input logic [3:0] en);
        gq.push_back('{id, addr, rd, ~rd, en, data});
    endtask

    task automatic push_txn(input logic id, input logic rd, input logic [31:0] addr,
                            input logic [31:0] data, input logic [3:0] en,
                            input logic [31:0] rdata);
        push_grant(id, rd, addr, data, en);
        dq.push_back('{id, rd, rdata});
    endtask

    task automatic drive(input logic id, input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] en);
        if (id == 1'b0) begin
            r0_read_en = rd; r0_write_en = wr; r0_addr = addr; r0_data_i = data; r0_data_en = en;
        end else begin
            r1_read_en = rd; r1_write_en = wr; r1_addr = addr; r1_data_i = data; r1_data_en = en;
        end
    endtask

    task automatic wait_done(input logic id);
        bit ok = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if ((id ? r1_done : r0_done) === 1'b1) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: requester %0d saw no done, expected done within 60 cycles", id);
        end
    endtask

    // Caller is aligned 1ns after a rising edge.
    task automatic run_txn(input logic id, input logic rd, input logic [31:0] addr,
                           input logic [31:0] data, input logic [3:0] en,
                           input bit drop, input bit check_idle);
        drive(id, rd, ~rd, addr, data, en);
        if (check_idle) begin
            @(negedge clk);
            check("idle_write_en", m_write_en, 1'b0);
            check("idle_data_en", m_data_en, 4'b0000);
        end
        wait_done(id);
        @(posedge clk); #1;
        check("busy_after_done", busy, 1'b0);
        if (drop) drive(id, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    endtask

    // Scripted memory: hit in the 2nd busy cycle, done in the 3rd.
    initial begin
        int cnt = 0;
        m_hit = 1'b0; m_done = 1'b0; m_data_o = 32'h12345678;
        forever begin
            @(posedge clk); #1;
            m_hit = 1'b0; m_done = 1'b0; m_data_o = 32'd0;
            if (busy && (m_read_en || m_write_en)) begin
                cnt++;
                if (cnt == 2) m_hit = 1'b1;
                if (cnt == 3) begin
                    m_done = 1'b1;
                    m_data_o = m_read_en ? mem_data(m_addr) : 32'd0;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Monitor: pops expected grants and completions as the DUT presents them.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                prev_busy = 1'b0;
            end else begin
                if (busy && !prev_busy) begin
                    if (gq.size() == 0) begin
                        check("unexpected_grant", {31'd0, owner, m_addr}, 64'd0);
                    end else begin
                        g_mon = gq.pop_front();
                        cur_owner = g_mon.id;
                        check("grant_owner", owner, g_mon.id);
                        check("grant_addr", m_addr, g_mon.addr);
                        check("grant_cmd", {m_read_en, m_write_en}, {g_mon.rd, g_mon.wr});
                        check("grant_data_en", m_data_en, g_mon.en);
                        if (g_mon.wr) check("grant_wdata", m_data_i, g_mon.data);
                    end
                end
                prev_busy = busy;
                if (!busy) check("idle_cmd", {m_read_en, m_write_en}, 2'b00);
                if (r0_hit || r1_hit) check("hit_owner", {r0_hit, r1_hit}, cur_owner ? 2'b01 : 2'b10);
                if (r0_done || r1_done) begin
                    if (dq.size() == 0) begin
                        check("unexpected_done", {r0_done, r1_done}, 2'b00);
                    end else begin
                        d_mon = dq.pop_front();
                        check("done_id", {r0_done, r1_done}, d_mon.id ? 2'b01 : 2'b10);
                        if (d_mon.rd) check("read_data", d_mon.id ? r1_data_o : r0_data_o, d_mon.data);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion before 100us");
        $fatal(1, "watchdog");
    end

    initial begin
        logic w;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_owner", owner, 1'b0);
        check("rst_m_cmd", {m_read_en, m_write_en}, 2'b00);
        check("rst_m_addr", m_addr, 32'd0);
        check("rst_resp", {r0_hit, r0_done, r1_hit, r1_done}, 4'b0000);
        check("rst_data_o", {r0_data_o, r1_data_o}, 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Single read on r0
        push_txn(1'b0, 1'b1, 32'h100, 32'd0, 4'd0, 32'hDEADBEEF);
        run_txn(1'b0, 1'b1, 32'h100, 32'd0, 4'd0, 1, 0);
        model_last = 1'b0;

        // r0 write and r1 read arrive together
        w = tie_winner();
        if (w == 1'b0) begin
            push_txn(1'b0, 1'b0, 32'h200, 32'h11223344, 4'hF, 32'd0);
            push_txn(1'b1, 1'b1, 32'h300, 32'd0, 4'd0, 32'hCAFEF00D);
        end else begin
            push_txn(1'b1, 1'b1, 32'h300, 32'd0, 4'd0, 32'hCAFEF00D);
            push_txn(1'b0, 1'b0, 32'h200, 32'h11223344, 4'hF, 32'd0);
        end
        fork
            run_txn(1'b0, 1'b0, 32'h200, 32'h11223344, 4'hF, 1, 0);
            run_txn(1'b1, 1'b1, 32'h300, 32'd0, 4'd0, 1, 0);
        join
        model_last = ~w;

        // Repeated contention rounds
        for (int k = 0; k < 4; k++) begin
            logic [31:0] a0, a1;
            a0 = 32'h700 + 32'(k) * 32'h10;
            a1 = 32'h800 + 32'(k) * 32'h10;
            w = tie_winner();
            if (w == 1'b0) begin
                push_txn(1'b0, 1'b1, a0, 32'd0, 4'd0, mem_data(a0));
                push_txn(1'b1, 1'b0, a1, 32'(k), 4'hF, 32'd0);
            end else begin
                push_txn(1'b1, 1'b0, a1, 32'(k), 4'hF, 32'd0);
                push_txn(1'b0, 1'b1, a0, 32'd0, 4'd0, mem_data(a0));
            end
            fork
                run_txn(1'b0, 1'b1, a0, 32'd0, 4'd0, 1, 0);
                run_txn(1'b1, 1'b0, a1, 32'(k), 4'hF, 1, 0);
            join
            model_last = ~w;
        end

        // r0 re-requests immediately after its done while r1 keeps waiting
        w = tie_winner();
`ifdef MEM_ARB_ROUND_ROBIN_EN
        if (w == 1'b0) begin
            push_txn(1'b0, 1'b1, 32'h900, 32'd0, 4'd0, mem_data(32'h900));
            push_txn(1'b1, 1'b1, 32'h980, 32'd0, 4'd0, mem_data(32'h980));
            push_txn(1'b0, 1'b1, 32'h940, 32'd0, 4'd0, mem_data(32'h940));
        end else begin
            push_txn(1'b1, 1'b1, 32'h980, 32'd0, 4'd0, mem_data(32'h980));
            push_txn(1'b0, 1'b1, 32'h900, 32'd0, 4'd0, mem_data(32'h900));
            push_txn(1'b0, 1'b1, 32'h940, 32'd0, 4'd0, mem_data(32'h940));
        end
`else
        push_txn(1'b0, 1'b1, 32'h900, 32'd0, 4'd0, mem_data(32'h900));
        push_txn(1'b0, 1'b1, 32'h940, 32'd0, 4'd0, mem_data(32'h940));
        push_txn(1'b1, 1'b1, 32'h980, 32'd0, 4'd0, mem_data(32'h980));
`endif
        fork
            begin
                run_txn(1'b0, 1'b1, 32'h900, 32'd0, 4'd0, 0, 0);
                run_txn(1'b0, 1'b1, 32'h940, 32'd0, 4'd0, 1, 0);
            end
            run_txn(1'b1, 1'b1, 32'h980, 32'd0, 4'd0, 1, 0);
        join
`ifdef MEM_ARB_ROUND_ROBIN_EN
        model_last = 1'b0;
`else
        model_last = 1'b1;
`endif

        // r1 aborts before hit; a stray done afterwards must not reach anyone
        push_grant(1'b1, 1'b1, 32'hA00, 32'd0, 4'd0);
        drive(1'b1, 1'b1, 1'b0, 32'hA00, 32'd0, 4'd0);
        @(posedge clk);
        @(negedge clk); #1;
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        #1;
        check("abort_read_en", m_read_en, 1'b0);
        check("abort_busy_hold", busy, 1'b1);
        @(posedge clk); #1;
        check("abort_idle", busy, 1'b0);
        #1;
        m_done = 1'b1;
        @(negedge clk);
        check("stray_done", {r0_done, r1_done}, 2'b00);
        @(posedge clk); #1;

        // Reset pulse after hit, before done
        push_grant(1'b0, 1'b1, 32'hB00, 32'd0, 4'd0);
        drive(1'b0, 1'b1, 1'b0, 32'hB00, 32'd0, 4'd0);
        begin
            bit seen = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (r0_hit === 1'b1) begin
                    seen = 1;
                    break;
                end
            end
            check("rst_mid_hit_seen", seen, 1'b1);
        end
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_read_en", m_read_en, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        @(negedge clk);
        check("rst_mid_no_done", {r0_done, r1_done}, 2'b00);
        rst_n = 1'b1;
        model_last = 1'b1;
        @(posedge clk); #1;
        push_txn(1'b0, 1'b1, 32'hC00, 32'd0, 4'd0, mem_data(32'hC00));
        run_txn(1'b0, 1'b1, 32'hC00, 32'd0, 4'd0, 1, 0);

        // Byte write: enables reach memory only while busy
        push_txn(1'b0, 1'b0, 32'h600, 32'h0000AB00, 4'b0010, 32'd0);
        run_txn(1'b0, 1'b0, 32'h600, 32'h0000AB00, 4'b0010, 1, 1);

        repeat (3) @(posedge clk);
        check("grants_left", gq.size(), 0);
        check("dones_left", dq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
